ico_spi_ctrl: RTL

SPI slave front-end that sits directly upstream of the control endpoints (echo test and friends) on the spi_ctrl_* bus. Samples the external SPI pins (mode 0, MSB first) in the clk domain. First byte of each transaction is an endpoint address, which drives epsel. Converts later byte traffic into the hd/so/si strobe protocol and shifts the endpoint's spi_ctrl_do back out on MISO.

---
 rtl/ico_spi_pkg.sv | 15 +
 rtl/ico_spi_sync.sv | 22 ++
 rtl/ico_spi_ctrl.sv | 107 ++++++++++
 3 files changed

// File: rtl/ico_spi_pkg.sv
// ico_spi_pkg: shared types and constants for the SPI control front-end
package ico_spi_pkg;

    localparam int SPI_BW = 8;
    localparam logic [SPI_BW-1:0] DEF_EP_ADDR = 8'h01;

    typedef enum logic [2:0] {
        IDLE,
        RX_ADDR,
        LOAD_FIRST,
        RX_DATA,
        POST
    } state_t;

endpackage

// File: rtl/ico_spi_sync.sv
// ico_spi_sync: 2-FF synchronizer with rising/falling edge detect on the synchronized level
module ico_spi_sync (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q,
    output logic rise,
    output logic fall
);

    logic [2:0] sr;

    // two metastability stages plus one history stage for edge detection
    always_ff @(posedge clk or posedge reset)
        if (reset) sr <= '0;
        else sr <= {sr[1:0], d};

    assign q    = sr[1];
    assign rise = sr[1] & ~sr[2];
    assign fall = ~sr[1] & sr[2];

endmodule

// File: rtl/ico_spi_ctrl.sv
// ico_spi_ctrl: SPI mode-0 slave that addresses a control endpoint and runs the hd/so/si strobe protocol
module ico_spi_ctrl
    import ico_spi_pkg::*;
#(
    parameter logic [SPI_BW-1:0] EP_ADDR = DEF_EP_ADDR,
    parameter int                CLK_KHZ = 12000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              spi_sck,
    input  logic              spi_csn,
    input  logic              spi_mosi,
    output logic              spi_miso,
    output logic              spi_ctrl_si,
    output logic              spi_ctrl_so,
    output logic              spi_ctrl_hd,
    output logic [SPI_BW-1:0] spi_ctrl_di,
    input  logic [SPI_BW-1:0] spi_ctrl_do,
    output logic              epsel
);

    logic sck_q, sck_rise, sck_fall;
    logic csn_q, csn_rise, csn_fall;
    logic mosi_q, mosi_rise, mosi_fall;
    logic unused_ok;

    state_t            state;
    logic [2:0]        cnt;
    logic [SPI_BW-2:0] rx_sh;
    logic [SPI_BW-1:0] rx_lat;
    logic [SPI_BW-1:0] tx_sh;
    logic [SPI_BW-1:0] rx_byte;
    logic              byte_done;
    logic              active;

    ico_spi_sync u_sck (.clk(clk), .reset(reset), .d(spi_sck),  .q(sck_q),  .rise(sck_rise),  .fall(sck_fall));
    ico_spi_sync u_csn (.clk(clk), .reset(reset), .d(spi_csn),  .q(csn_q),  .rise(csn_rise),  .fall(csn_fall));
    ico_spi_sync u_mosi(.clk(clk), .reset(reset), .d(spi_mosi), .q(mosi_q), .rise(mosi_rise), .fall(mosi_fall));

    assign unused_ok = &{1'b0, sck_q, csn_rise, mosi_rise, mosi_fall, (CLK_KHZ > 0)};

    assign active    = state != IDLE;
    assign rx_byte   = {rx_sh, mosi_q};
    assign byte_done = sck_rise && cnt == 3'd7;
    assign spi_miso  = ~csn_q & tx_sh[SPI_BW-1];

    // bit shifting, transaction FSM and registered strobes; csn high always wins
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            state       <= IDLE;
            cnt         <= '0;
            rx_sh       <= '0;
            rx_lat      <= '0;
            tx_sh       <= '0;
            spi_ctrl_di <= '0;
            spi_ctrl_hd <= 1'b0;
            spi_ctrl_so <= 1'b0;
            spi_ctrl_si <= 1'b0;
            epsel       <= 1'b0;
        end else begin
            spi_ctrl_hd <= 1'b0;
            spi_ctrl_so <= 1'b0;
            spi_ctrl_si <= 1'b0;
            if (active && sck_rise) begin
                cnt   <= cnt + 3'd1;
                rx_sh <= rx_byte[SPI_BW-2:0];
            end
            // the falling edge right after a byte boundary must keep the freshly loaded MSB
            if (active && sck_fall && cnt != 3'd0)
                tx_sh <= {tx_sh[SPI_BW-2:0], 1'b0};
            if (csn_q) begin
                state <= IDLE;
                epsel <= 1'b0;
            end else begin
                case (state)
                    IDLE: if (csn_fall) begin
                        cnt   <= '0;
                        tx_sh <= '0;
                        state <= RX_ADDR;
                    end
                    RX_ADDR: if (byte_done) begin
                        spi_ctrl_di <= rx_byte;
                        spi_ctrl_hd <= 1'b1;
                        epsel       <= rx_byte == EP_ADDR;
                        state       <= LOAD_FIRST;
                    end
                    LOAD_FIRST: begin
                        tx_sh       <= spi_ctrl_do;
                        spi_ctrl_so <= 1'b1;
                        state       <= RX_DATA;
                    end
                    RX_DATA: if (byte_done) begin
                        tx_sh  <= spi_ctrl_do;
                        rx_lat <= rx_byte;
                        state  <= POST;
                    end
                    POST: begin
                        spi_ctrl_di <= rx_lat;
                        spi_ctrl_si <= 1'b1;
                        state       <= RX_DATA;
                    end
                    default: state <= IDLE;
                endcase
            end
        end

endmodule
